// File: rtl/sm_pwm.sv
// Sign-magnitude PWM modulator: per-frame duty quantisation with first-order error
// feedback, complementary H-bridge drive and a dead-time blank on polarity change.
module sm_pwm #(
  parameter int CNT_W = 8,
  parameter int DT    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [15:0]      in_mag,
  input  logic             in_sign,
  output logic             pwm_p,
  output logic             pwm_n,
  output logic             frame,
  output logic [CNT_W-1:0] duty
);

  localparam int ERR_W = 16 - CNT_W;
  localparam logic [CNT_W-1:0] MAX  = '1;
  localparam logic [CNT_W-1:0] DT_C = CNT_W'(DT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             sign_q, sign_d;
  logic [CNT_W-1:0] blank_q, blank_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pwm_p_q, pwm_p_d;
  logic             pwm_n_q, pwm_n_d;
  logic             frame_q, frame_d;

  logic             restart;
  logic             boundary;
  logic             same;
  logic             active;
  logic [16:0]      sum;

  always_comb begin
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    sign_d  = sign_q;
    blank_d = blank_q;
    err_d   = err_q;

    // cnt == 0 without a frame pulse only happens straight after reset or a
    // disabled cycle, so that is the first enabled edge.
    restart  = ~frame_q & (cnt_q == '0);
    boundary = en & (restart | (cnt_q == MAX));
    same     = (in_sign == sign_q);
    sum      = {1'b0, in_mag} + (same ? {{(CNT_W+1){1'b0}}, err_q} : 17'd0);

    if (!en) begin
      cnt_d = '0;
      err_d = '0;
    end else begin
      cnt_d = boundary ? '0 : cnt_q + 1'b1;
      if (boundary) begin
        if (sum[16]) begin
          duty_d = MAX;
          err_d  = '1;
        end else begin
          duty_d = sum[15:ERR_W];
          err_d  = sum[ERR_W-1:0];
        end
        blank_d = same ? '0 : DT_C;
        sign_d  = in_sign;
      end
    end

    // Outputs are registered from next-state values so they line up with cnt.
    active  = (cnt_d >= blank_d) & (cnt_d < duty_d);
    pwm_p_d = en & ~sign_d & active;
    pwm_n_d = en &  sign_d & active;
    frame_d = en & (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      duty_q  <= '0;
      sign_q  <= 1'b0;
      blank_q <= '0;
      err_q   <= '0;
      pwm_p_q <= 1'b0;
      pwm_n_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      sign_q  <= sign_d;
      blank_q <= blank_d;
      err_q   <= err_d;
      pwm_p_q <= pwm_p_d;
      pwm_n_q <= pwm_n_d;
      frame_q <= frame_d;
    end
  end

  assign pwm_p = pwm_p_q;
  assign pwm_n = pwm_n_q;
  assign frame = frame_q;
  assign duty  = duty_q;

endmodule

// File: tb/tb_sm_pwm.sv
// Directed bench for sm_pwm: frame-by-frame drive, feedback, saturation, dead-time,
// enable toggle and asynchronous reset.
module tb_sm_pwm;
  localparam int CNT_W = 8;
  localparam int DT    = 4;
  localparam int FLEN  = 1 << CNT_W;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [15:0]      in_mag;
  logic             in_sign;
  logic             pwm_p;
  logic             pwm_n;
  logic             frame;
  logic [CNT_W-1:0] duty;

  int n_chk = 0;
  int n_err = 0;

  sm_pwm #(.CNT_W(CNT_W), .DT(DT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .in_mag (in_mag),
    .in_sign(in_sign),
    .pwm_p  (pwm_p),
    .pwm_n  (pwm_n),
    .frame  (frame),
    .duty   (duty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at the negedge of cnt == 0; returns at the negedge of the next frame's cnt == 0.
  // Loads the sample for the following frame partway through.
  task automatic run_frame(input string tag, input logic [15:0] nm, input logic ns,
                           input int e_duty, input int e_np, input int e_nn,
                           input int e_first, input int e_last);
    int np, nn, both, nfr, first, last;
    np = 0; nn = 0; both = 0; nfr = 0; first = -1; last = -1;
    chk({tag, ".frame0"}, frame, 1);
    chk({tag, ".duty"}, duty, e_duty);
    for (int k = 0; k < FLEN; k++) begin
      if (pwm_p) np++;
      if (pwm_n) nn++;
      if (pwm_p & pwm_n) both++;
      if (frame) nfr++;
      if (pwm_p | pwm_n) begin
        if (first < 0) first = k;
        last = k;
      end
      if (k == 10) begin
        in_mag  = nm;
        in_sign = ns;
      end
      @(negedge clk);
    end
    chk({tag, ".np"}, np, e_np);
    chk({tag, ".nn"}, nn, e_nn);
    chk({tag, ".first"}, first, e_first);
    chk({tag, ".last"}, last, e_last);
    chk({tag, ".both"}, both, 0);
    chk({tag, ".nframe"}, nfr, 1);
  endtask

  initial begin
    logic act;
    rst_n   = 1'b0;
    en      = 1'b1;
    in_mag  = 16'h8000;
    in_sign = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.pwm_p", pwm_p, 0);
    chk("rst.pwm_n", pwm_n, 0);
    chk("rst.frame", frame, 0);
    chk("rst.duty", duty, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_frame("f1_half",   16'h8000, 1'b0, 128, 128, 0,   0,   127);
    run_frame("f2_half",   16'h0080, 1'b0, 128, 128, 0,   0,   127);
    run_frame("f3_fb0",    16'h0080, 1'b0, 0,   0,   0,   -1,  -1);
    run_frame("f4_fb1",    16'h0080, 1'b0, 1,   1,   0,   0,   0);
    run_frame("f5_fb0",    16'h0180, 1'b1, 0,   0,   0,   -1,  -1);
    run_frame("f6_discard",16'h0000, 1'b0, 1,   0,   0,   -1,  -1);
    run_frame("f7_zero",   16'h0300, 1'b1, 0,   0,   0,   -1,  -1);
    run_frame("f8_le_dt",  16'h8000, 1'b0, 3,   0,   0,   -1,  -1);
    run_frame("f9_flip_p", 16'h8000, 1'b0, 128, 124, 0,   4,   127);
    run_frame("f10_a",     16'hFFFF, 1'b0, 128, 128, 0,   0,   127);
    run_frame("f11_sat1",  16'hFFFF, 1'b0, 255, 255, 0,   0,   254);
    run_frame("f12_sat2",  16'h8000, 1'b0, 255, 255, 0,   0,   254);
    run_frame("f13_resid", 16'h8000, 1'b1, 128, 128, 0,   0,   127);
    run_frame("f14_b",     16'h8000, 1'b1, 128, 0,   124, 4,   127);
    run_frame("f15_c",     16'h8000, 1'b1, 128, 0,   128, 0,   127);

    // enable dropped at cnt 50 of a negative frame, restored 10 cycles later
    for (int k = 0; k < 50; k++) @(negedge clk);
    chk("dis.pre_pwm_n", pwm_n, 1);
    en      = 1'b0;
    in_mag  = 16'h4000;
    in_sign = 1'b0;
    @(negedge clk);
    chk("dis.pwm_p", pwm_p, 0);
    chk("dis.pwm_n", pwm_n, 0);
    chk("dis.frame", frame, 0);
    act = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      act = act | pwm_p | pwm_n | frame;
    end
    chk("dis.quiet", act, 0);
    chk("dis.duty_hold", duty, 128);
    en = 1'b1;
    @(negedge clk);
    run_frame("reen",      16'h4000, 1'b0, 64,  60,  0,   4,   63);

    // asynchronous reset at cnt 50 of a positive frame
    for (int k = 0; k < 50; k++) @(negedge clk);
    chk("ar.pre_pwm_p", pwm_p, 1);
    chk("ar.pre_duty", duty, 64);
    rst_n   = 1'b0;
    in_mag  = 16'h8000;
    in_sign = 1'b1;
    #1;
    chk("ar.pwm_p", pwm_p, 0);
    chk("ar.frame", frame, 0);
    chk("ar.duty", duty, 0);
    @(negedge clk);
    chk("ar.duty_held", duty, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame("post_rst",  16'h8000, 1'b1, 128, 0,   124, 4,   127);
    run_frame("post_rst2", 16'h8000, 1'b1, 128, 0,   128, 0,   127);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/sm_pwm.md
# sm_pwm

Sign-magnitude PWM modulator that sits directly downstream of the delayed-difference stage. Once per frame it samples a 16-bit magnitude and sign, quantises the magnitude to a CNT_W-bit duty with first-order error feedback, and drives a complementary pair of PWM outputs for an H-bridge. A dead-time blank is inserted whenever the polarity flips between frames.

## Interface
- CNT_W, 8: frame counter width. Frame length is 2^CNT_W cycles; duty resolution is CNT_W bits; 1 ≤ CNT_W ≤ 15.
- DT, 4: dead-time blank in cycles, applied on a polarity change; 0 ≤ DT < 2^CNT_W.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  modulator enable
- in_mag  in  16  magnitude; registered upstream, so stable for a full cycle
- in_sign  in  1  1 = negative
- pwm_p  out  1  positive-polarity drive
- pwm_n  out  1  negative-polarity drive
- frame  out  1  one-cycle pulse in the first cycle of each frame (cnt == 0)
- duty  out  CNT_W  duty of the current frame, for debug and monitoring

## Operation
- Registers:
  - cnt: CNT_W bits
  - duty: CNT_W bits
  - sign: 1 bit
  - blank: CNT_W bits
  - err: 16−CNT_W bits, the quantisation residual
- All registers reset to 0. All outputs reset to 0.
- en = 0:
  - cnt is held at 0 and err is cleared to 0.
  - pwm_p, pwm_n and frame are driven 0.
  - duty and sign hold their values.
- en = 1: cnt increments every cycle and wraps from MAX = 2^CNT_W−1 to 0.
- Frame update happens on the edge that leaves cnt == MAX. It also happens on the first edge with en = 1 after en = 0 or reset, because cnt is 0 in that cycle and it is treated as the frame boundary.
  - On that edge the block samples in_mag and in_sign.
  - If in_sign == sign, compute sum = in_mag + err, zero-extended to 17 bits. Otherwise sum = in_mag and the residual is discarded.
  - If sum[16] == 0: duty ← sum[15:16−CNT_W] and err ← sum[15−CNT_W:0].
  - If sum[16] == 1 (saturation): duty ← MAX and err ← all ones.
  - blank ← DT if in_sign != sign, else 0.
  - sign ← in_sign.
- Drive rule within a frame, for the cycle with cnt == k:
  - pwm_p = en & ~sign & (k ≥ blank) & (k < duty)
  - pwm_n = en & sign & (k ≥ blank) & (k < duty)
- Consequences of the drive rule:
  - duty = 0 gives no pulse.
  - duty ≤ blank gives no pulse.
  - The maximum on-time is MAX cycles, so each output is low for at least one cycle per frame.
  - pwm_p and pwm_n are never both 1.

## Timing
- All outputs are registered, computed from next-state values, and glitch-free.
- pwm_p, pwm_n and frame reflect cnt, duty, sign and blank in the same cycle, with no additional lag.
- Latency: a sample captured on the edge that ends cycle cnt == MAX governs the frame starting in the very next cycle.
- Input values presented at any other time are ignored.
- The first frame after reset or enable:
  - It captures the input present on the first enabled edge.
  - It compares against sign = 0, or against the retained sign after an enable toggle.
- Asynchronous reset mid-frame: outputs go to 0 immediately. The first frame after release follows the enable rule above.
- en falling mid-frame: outputs are 0 from the next cycle, and cnt = 0.

## Test plan
- Reset with en = 1, in_mag = 0x8000, in_sign = 0, CNT_W = 8, DT = 4 -> frame pulses every 256 cycles; pwm_p is high for cnt 0..127 of each frame; pwm_n stays 0; duty = 128.
- Error feedback with in_mag = 0x0080, sign = 0 (half an LSB) -> duty alternates 0, 1, 0, 1 across frames; average pwm_p is 0.5 cycles per frame; err alternates 0x80, 0x00.
- Saturation with in_mag = 0xFFFF held -> first frame duty = 255, err = 0xFF; second frame sum overflows, so duty = 255 and err = 0xFF; pwm_p is low exactly at cnt = 255.
- Polarity flip: frame A is 0x8000 / sign 0, then frame B is 0x8000 / sign 1 -> in frame B, pwm_n is high for cnt 4..127, pwm_p is 0 throughout, and the outputs are never both 1. Frame C with the same sign 1 has pwm_n high for cnt 0..127.
- Sign flip with residual: with err = 0x80 accumulated on sign 0, apply 0x0180 / sign 1 -> duty = 1 and err = 0x80 from in_mag only, so the residual is discarded. Also apply 0x0300 / sign 1 after a flip -> duty = 3, which is ≤ DT, so there is no pulse.
- en deasserted at cnt = 50, then reasserted 10 cycles later -> outputs are 0 from the next cycle and frame stays 0. On reassert, frame = 1 in the first enabled cycle and the new sample is used. The same check is repeated with rst_n pulsed at cnt = 50: outputs go to 0 asynchronously and all registers are 0.
